mole_round_ctrl: RTL and testbench
==================================

MOLE_ROUND_CTRL -- requirements
Module: mole_round_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 25000000, clk cycles per game tick.
REQ-002 Parameter WIN_SCORE, default 3, hits needed to win; legal range 1..15.
REQ-003 Parameter HIT_WINDOW, default 4, ticks a mole stays lit; legal range 1..15.
REQ-004 Parameter WIN_HOLD, default 2, ticks the win/lose pattern is shown.
REQ-005 Parameter MAX_MISSES, default 3, misses allowed before loss (LIVES_EN builds only).
REQ-006 clk  in  1  system clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  level request to begin a game; synchronous to clk.
REQ-009 sw  in  16  raw board switches; asynchronous to clk.
REQ-010 rnd  in  4  random mole index from the LFSR; sampled only in SPAWN.
REQ-011 led  out  16  mole/result pattern, registered.
REQ-012 score  out  4  current hit count, registered.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 win  out  1  one-clk pulse on entry to WIN.
REQ-015 lose  out  1  one-clk pulse on entry to LOSE; constant 0 without LIVES_EN.

Function
REQ-016 Tick divider counts 0..TICK_DIV-1 and asserts an internal tick for one clk when count = TICK_DIV-1, then wraps to 0.
REQ-017 The sw bus passes through a 2-flop synchroniser; a rising edge is sync stage 2 = 1 while the previous sample = 0, one flag per bit.
REQ-018 States: IDLE, SPAWN, ARMED, HIT, MISS, WIN, LOSE.
REQ-019 IDLE: led=0; start=1 -> clear score, miss count, and tick divider; go to SPAWN next clk.
REQ-020 SPAWN: on tick, latch target=rnd, led=one-hot(target), window=HIT_WINDOW; go to ARMED.
REQ-021 ARMED: rising edge on sw[target] with no other sw edge in the same clk -> HIT.
REQ-022 ARMED: rising edge on any non-target switch, including the same clk as a target edge, -> MISS.
REQ-023 ARMED: each tick decrements window; a tick with window=1 and no sw edge -> MISS.
REQ-024 Sw edge and window expiry in the same clk: the edge decides (REQ-021/022); the timeout is ignored.
REQ-025 HIT (one clk): led=0, score+1; new score = WIN_SCORE -> WIN, else -> SPAWN.
REQ-026 MISS (one clk): led=0; -> SPAWN (see REQ-032 for LIVES_EN).
REQ-027 WIN: led=16'hFFFF for WIN_HOLD ticks, then IDLE; score held until the next start.
REQ-028 start is ignored outside IDLE; rnd equal to the previous target is legal.
REQ-029 The switch-to-led latency from SPAWN tick to the lit led is 1 clk; from sw pin to the HIT transition it is at most 3 clk.

Reset
REQ-030 rst_n=0 asynchronously forces IDLE with led=0, score=0, busy=0, win=0, lose=0, the divider, window, miss count and target at 0, and synchroniser flops at 0, including mid-game.
REQ-031 The first clk after release takes no sw edge, because the synchroniser history is 0; a switch held high through reset produces exactly one edge 2 clk after release.

Configuration
REQ-032 With LIVES_EN defined: a 4-bit miss count increments in MISS; reaching MAX_MISSES -> LOSE; otherwise -> SPAWN.
REQ-033 LOSE: led=16'h00FF for WIN_HOLD ticks, lose pulses on entry, then IDLE.
REQ-034 Without LIVES_EN: no miss count, MISS always -> SPAWN, lose tied 0, and the LOSE state is unreachable.

Verification (TICK_DIV=4, WIN_SCORE=3, HIT_WINDOW=4)
REQ-035 Reset mid-ARMED with led=16'h0020 -> led=0, score=0, busy=0 in the same cycle, without waiting for clk.
REQ-036 start=1, rnd=5, sw[5] rises 2 ticks after spawn -> led=16'h0020, then HIT, score=1, next SPAWN.
REQ-037 Three correct hits -> score=3, win pulses 1 clk, led=16'hFFFF for 8 clk, IDLE, score stays 3.
REQ-038 rnd=2, sw[2] and sw[7] rise in the same clk -> MISS, score unchanged.
REQ-039 rnd=9, no switch activity -> MISS exactly on the 4th tick after spawn; with a target edge in that same clk -> HIT.
REQ-040 LIVES_EN, MAX_MISSES=3, three timeouts -> lose pulse, led=16'h00FF for 8 clk, then IDLE; without LIVES_EN -> the game continues and lose stays 0.

Source files
------------

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: spawns one lit mole per round, scores
// synchronised switch hits and shows a win/lose pattern. Define LIVES_EN for the miss limit.
module mole_round_ctrl #(
  parameter int TICK_DIV   = 25000000,
  parameter int WIN_SCORE  = 3,
  parameter int HIT_WINDOW = 4,
  parameter int WIN_HOLD   = 2,
  parameter int MAX_MISSES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] sw,
  input  logic [3:0]  rnd,
  output logic [15:0] led,
  output logic [3:0]  score,
  output logic        busy,
  output logic        win,
  output logic        lose
);

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_ARMED, S_HIT, S_MISS, S_WIN, S_LOSE
  } state_t;

  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;

  if (TICK_DIV < 1 || WIN_HOLD < 1 || WIN_SCORE < 1 || WIN_SCORE > 15 ||
      HIT_WINDOW < 1 || HIT_WINDOW > 15 || MAX_MISSES < 1 || MAX_MISSES > 15) begin : g_param_check
    $error("mole_round_ctrl: parameter out of legal range");
  end

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick, div_clr;
  logic [15:0]         sw_meta, sw_sync, sw_prev, sw_rise;
  logic [15:0]         tgt_mask;
  logic                tgt_hit, other_hit;
  logic [3:0]          target, target_d;
  logic [3:0]          window, window_d;
  logic [HOLD_W-1:0]   hold, hold_d;
  logic [15:0]         led_d;
  logic [3:0]          score_d;
  logic                win_d;
`ifdef LIVES_EN
  logic [3:0]          miss, miss_d;
  logic                lose_d;
`endif

  // NOTE: async active-low reset; all sequential state uses non-blocking (<=) assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                div_cnt <= '0;
    else if (div_clr || tick)  div_cnt <= '0;
    else                       div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  // Two flops for metastability, a third as the previous sample for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
      sw_prev <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      sw_prev <= sw_sync;
    end
  end

  assign sw_rise   = sw_sync & ~sw_prev;
  assign tgt_mask  = 16'h0001 << target;
  assign tgt_hit   = |(sw_rise & tgt_mask);
  assign other_hit = |(sw_rise & ~tgt_mask);

  // State and registered outputs; next values come from the two comb processes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      target <= '0;
      window <= '0;
      hold   <= '0;
      led    <= '0;
      score  <= '0;
      win    <= 1'b0;
`ifdef LIVES_EN
      miss   <= '0;
      lose   <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      target <= target_d;
      window <= window_d;
      hold   <= hold_d;
      led    <= led_d;
      score  <= score_d;
      win    <= win_d;
`ifdef LIVES_EN
      miss   <= miss_d;
      lose   <= lose_d;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SPAWN;
      S_SPAWN: if (tick)  state_nxt = S_ARMED;
      S_ARMED: begin
        // A switch edge outranks a window expiry in the same clk.
        if (other_hit)                       state_nxt = S_MISS;
        else if (tgt_hit)                    state_nxt = S_HIT;
        else if (tick && window == 4'd1)     state_nxt = S_MISS;
      end
      S_HIT:   state_nxt = (score == 4'(WIN_SCORE)) ? S_WIN : S_SPAWN;
`ifdef LIVES_EN
      S_MISS:  state_nxt = (miss == 4'(MAX_MISSES)) ? S_LOSE : S_SPAWN;
`else
      S_MISS:  state_nxt = S_SPAWN;
`endif
      S_WIN, S_LOSE:
        if (tick && hold == HOLD_W'(WIN_HOLD - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    led_d    = led;
    score_d  = score;
    target_d = target;
    window_d = window;
    hold_d   = hold;
    win_d    = 1'b0;
    div_clr  = 1'b0;
`ifdef LIVES_EN
    miss_d   = miss;
    lose_d   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        led_d = '0;
        if (start) begin
          score_d = '0;
          div_clr = 1'b1;
`ifdef LIVES_EN
          miss_d  = '0;
`endif
        end
      end
      S_SPAWN: if (tick) begin
        target_d = rnd;
        led_d    = 16'h0001 << rnd;
        window_d = 4'(HIT_WINDOW);
      end
      S_ARMED: begin
        if (state_nxt == S_HIT) begin
          led_d   = '0;
          score_d = score + 4'd1;
        end else if (state_nxt == S_MISS) begin
          led_d   = '0;
`ifdef LIVES_EN
          miss_d  = miss + 4'd1;
`endif
        end else if (tick) begin
          window_d = window - 4'd1;
        end
      end
      // The divider restarts on result entry so the pattern lasts exactly WIN_HOLD ticks.
      S_HIT: if (state_nxt == S_WIN) begin
        led_d   = 16'hFFFF;
        win_d   = 1'b1;
        hold_d  = '0;
        div_clr = 1'b1;
      end
`ifdef LIVES_EN
      S_MISS: if (state_nxt == S_LOSE) begin
        led_d   = 16'h00FF;
        lose_d  = 1'b1;
        hold_d  = '0;
        div_clr = 1'b1;
      end
`endif
      S_WIN, S_LOSE: if (tick) begin
        if (state_nxt == S_IDLE) led_d  = '0;
        else                     hold_d = hold + 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);
`ifndef LIVES_EN
  assign lose = 1'b0;
`endif

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Self-checking bench for mole_round_ctrl: directed round table, reset corners
// and randomized games scored by an outcome-level reference model.
module tb_mole_round_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int WIN_SCORE  = 3;
  localparam int HIT_WINDOW = 4;
  localparam int WIN_HOLD   = 2;
  localparam int MAX_MISSES = 3;

  localparam int SYNC_LAT    = 3;                      // sw pin to state change
  localparam int WINDOW_CLKS = HIT_WINDOW * TICK_DIV;  // spawn to timeout
  localparam int DEADLINE    = WINDOW_CLKS - SYNC_LAT; // last drive clk that still scores

  localparam int K_HIT     = 0;
  localparam int K_WRONG   = 1;
  localparam int K_BOTH    = 2;
  localparam int K_TIMEOUT = 3;

  logic        clk, rst_n, start;
  logic [15:0] sw;
  logic [3:0]  rnd;
  logic [15:0] led;
  logic [3:0]  score;
  logic        busy, win, lose;

  int n_checks = 0;
  int n_errors = 0;

  mole_round_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .WIN_SCORE (WIN_SCORE),
    .HIT_WINDOW(HIT_WINDOW),
    .WIN_HOLD  (WIN_HOLD),
    .MAX_MISSES(MAX_MISSES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sw   (sw),
    .rnd  (rnd),
    .led  (led),
    .score(score),
    .busy (busy),
    .win  (win),
    .lose (lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] r;
    int         kind;
    int         d;
    logic [3:0] w;
    int         exp_dark;
    int         exp_score;
  } round_vec_t;

  round_vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_lit(input logic [3:0] r);
    int n;
    logic [15:0] exp_led;
    rnd = r;
    exp_led = 16'h0001 << r;
    n = 0;
    while (led == 16'h0 && n < 40) begin
      step();
      n++;
    end
    check("spawn_led", 32'(led), 32'(exp_led));
  endtask

  // Drives the chosen switch pattern d clks after the mole lights and
  // counts clks until the mole goes dark.
  task automatic play_round(input logic [3:0] r, input int kind, input int d,
                            input logic [3:0] w, input int exp_dark, input int exp_score);
    logic [15:0] pat;
    int n;
    wait_lit(r);
    pat = '0;
    if (kind == K_HIT || kind == K_BOTH)   pat[r] = 1'b1;
    if (kind == K_WRONG || kind == K_BOTH) pat[w] = 1'b1;
    n = 0;
    while (led != 16'h0 && n < 40) begin
      if (kind != K_TIMEOUT && n == d) sw = pat;
      step();
      n++;
    end
    sw = '0;
    check("dark_cycles", 32'(n), 32'(exp_dark));
    check("score", 32'(score), 32'(exp_score));
    check("busy_in_round", 32'(busy), 32'd1);
    check("no_result_pulse", 32'({win, lose}), 32'd0);
  endtask

  task automatic check_end(input logic [15:0] exp_led, input bit is_win);
    int n;
    step();
    if (is_win) check("win_pulse", 32'(win), 32'd1);
    else        check("lose_pulse", 32'(lose), 32'd1);
    check("end_led", 32'(led), 32'(exp_led));
    step();
    n = 1;
    check("pulse_one_clk", 32'({win, lose}), 32'd0);
    while (led == exp_led && n < 40) begin
      step();
      n++;
    end
    check("end_hold_clks", 32'(n), 32'(WIN_HOLD * TICK_DIV));
    check("idle_led", 32'(led), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic start_game();
    check("pre_start_idle", 32'(busy), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_score_clr", 32'(score), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  int         m_score, m_miss, rounds, kind, d;
  bit         done;
  logic [3:0] r, w;

  initial begin
    tbl[0] = '{4'd5,  K_HIT,     8,  4'd0, 11, 1};
    tbl[1] = '{4'd2,  K_BOTH,    3,  4'd7,  6, 1};
    tbl[2] = '{4'd9,  K_TIMEOUT, 0,  4'd0, 16, 1};
    tbl[3] = '{4'd9,  K_HIT,     13, 4'd0, 16, 2};
    tbl[4] = '{4'd15, K_HIT,     0,  4'd0,  3, 3};

    rst_n = 1'b0;
    start = 1'b0;
    sw    = '0;
    rnd   = '0;
    step();
    step();
    check("rst_led", 32'(led), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_win", 32'(win), 32'd0);
    check("rst_lose", 32'(lose), 32'd0);
    rst_n = 1'b1;
    step();

    // Directed game from the round table, ending in a win.
    start_game();
    for (int i = 0; i < 5; i++)
      play_round(tbl[i].r, tbl[i].kind, tbl[i].d, tbl[i].w, tbl[i].exp_dark, tbl[i].exp_score);
    check_end(16'hFFFF, 1'b1);
    check("score_held", 32'(score), 32'(WIN_SCORE));
    step();
    check("score_held_idle", 32'(score), 32'(WIN_SCORE));

    // Asynchronous reset while a mole is lit.
    start_game();
    play_round(4'd5, K_HIT, 0, 4'd0, 3, 1);
    wait_lit(4'd5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(led), 32'd0);
    check("async_rst_score", 32'(score), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);

    // A switch held high through reset gives one edge only, long before the mole lights.
    sw = 16'h0008;
    step();
    step();
    rst_n = 1'b1;
    start_game();
    play_round(4'd3, K_TIMEOUT, 0, 4'd0, WINDOW_CLKS, 0);
    do_reset();

    // Three timeouts in a row.
    start_game();
    for (int i = 0; i < 3; i++)
      play_round(4'(i + 4), K_TIMEOUT, 0, 4'd0, WINDOW_CLKS, 0);
`ifdef LIVES_EN
    check_end(16'h00FF, 1'b0);
`else
    wait_lit(4'd11);
    check("game_continues", 32'(busy), 32'd1);
    check("lose_tied_low", 32'(lose), 32'd0);
    do_reset();
`endif

    // Randomized games checked against the outcome-level model.
    for (int g = 0; g < 5; g++) begin
      start_game();
      m_score = 0;
      m_miss  = 0;
      rounds  = 0;
      done    = 1'b0;
      while (!done) begin
        r    = 4'($urandom_range(0, 15));
        w    = r ^ 4'($urandom_range(1, 15));
        kind = (rounds >= 8) ? K_HIT : int'($urandom_range(0, 3));
        d    = int'($urandom_range(0, DEADLINE));
        if (kind == K_HIT) m_score++;
        else               m_miss++;
        play_round(r, kind, d, w, (kind == K_TIMEOUT) ? WINDOW_CLKS : d + SYNC_LAT, m_score);
        if (m_score == WIN_SCORE) begin
          check_end(16'hFFFF, 1'b1);
          check("rand_score_held", 32'(score), 32'(WIN_SCORE));
          done = 1'b1;
        end
`ifdef LIVES_EN
        else if (m_miss == MAX_MISSES) begin
          check_end(16'h00FF, 1'b0);
          done = 1'b1;
        end
`endif
        rounds++;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
